conv1_out_mem_writer: RTL and testbench
=======================================

# conv1_out_mem_writer

Write-side address generator for the Convolution 1 layer output memory. It accepts a valid/ready stream of result pairs, one per output channel, from the conv1 datapath. Each pair is written to two write ports in row-major order over a ROWS x COLS feature map. It produces the write addresses, data and enable for both channel memories, then signals `done`; the P1 read counter consumes that memory afterwards.

## Interface
Parameters:
- DATA_W, 16, width of one conv1 result word
- ROWS, 24, feature-map rows
- COLS, 24, feature-map columns
- ADDR_W, 10, write-address width; ROWS*COLS + max(BASE1,BASE2) must be <= 2**ADDR_W
- BASE1, 0, base address of channel 1 map
- BASE2, 0, base address of channel 2 map

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse, begins a new frame
- in_valid  in  1  result pair present
- in_data1  in  DATA_W  channel 1 result
- in_data2  in  DATA_W  channel 2 result
- in_ready  out  1  writer accepts a pair this cycle
- wr_en  out  1  write strobe, common to both ports
- wr_addr1  out  ADDR_W  channel 1 write address
- wr_addr2  out  ADDR_W  channel 2 write address
- wr_data1  out  DATA_W  channel 1 write data
- wr_data2  out  DATA_W  channel 2 write data
- done  out  1  frame fully written; level, held

## Operation
- States:
  - IDLE: after reset.
  - WRITE: accepting pairs.
  - FLUSH: final write in flight.
  - DONE: frame complete.
- IDLE/DONE, `start`=1: go to WRITE, clear `row` and `col` to 0, drop `done`.
- `start` in WRITE or FLUSH is ignored. No restart mid-frame.
- WRITE: `in_ready`=1. Elsewhere `in_ready`=0 (combinational from state).
- A beat is accepted when `in_valid` and `in_ready` are both 1.
- On an accepted beat:
  - register `wr_data1/2` from `in_data1/2`.
  - set `wr_addr1` = BASE1 + row*COLS + col and `wr_addr2` = BASE2 + row*COLS + col.
  - `wr_en`=1 for exactly the next cycle.
- Counter advance per accepted beat:
  - `col`++.
  - When `col`==COLS-1: `col`→0 and `row`++.
  - When `row`==ROWS-1 and `col`==COLS-1: last beat. Go to FLUSH; counters are not advanced past the map.
- Address arithmetic: unsigned, computed at ADDR_W width. Implement row*COLS incrementally with a running `row_base` += COLS; no multiplier.
- FLUSH: lasts one cycle; the last write is on the port. Then go to DONE.
- DONE: `done`=1, held until the next `start`. `wr_en`=0.
- `in_valid` gaps in WRITE: no write, counters hold, `wr_en`=0.
- Extra `in_valid` outside WRITE: not accepted, no write.

## Timing
- Reset values: `wr_en`=0, `wr_addr1`=BASE1, `wr_addr2`=BASE2, `wr_data1/2`=0, `done`=0, `in_ready`=0, state IDLE, `row`=`col`=0.
- Asserting `rst_n`=0 at any time, including mid-frame, forces these values immediately; `wr_en` drops without waiting for a clock edge.
- `start` at edge t: `in_ready`=1 from cycle t+1.
- Beat accepted at edge e: `wr_en`/`wr_addr*`/`wr_data*` valid in cycle e+1.
- Throughput: one write per cycle with `in_valid` held high.
- Full frame with no gaps: first accept at edge t+1, last (ROWS*COLS-th) accept at edge t+ROWS*COLS, FLUSH (last `wr_en`) in the following cycle, `done`=1 one cycle after that.
  - Default 24x24: `start` at cycle 0 → `done` at cycle 578.
- `done` never rises in the same cycle as any `wr_en`.
- `start` in the same cycle `done`=1: `done` drops next cycle and a new frame begins. The old frame's data is already committed.

## Test plan
- Reset mid-frame: after 100 beats, pulse `rst_n` low → `wr_en`=0 immediately, `done`=0. Then `start` → first write to address 0 again.
- Default frame, `in_valid` tied 1, data = beat index → 576 writes:
  - `wr_addr1` 0..575 sequential, `wr_data1`=`wr_addr1`.
  - `done` rises at cycle 578 after `start` and stays high.
- Row wrap: BASE1=0, BASE2=576 → beat 24 writes `wr_addr1`=24, `wr_addr2`=600. Beat 575 writes 575/1151.
- Backpressure: `in_valid` toggling 1,0,0,1 → `wr_en` only on cycles after accepts, addresses contiguous, no duplicates or skips. Total writes = 576.
- `start` pulsed at beat 300 → ignored: addresses continue 300,301,… and `done` arrives once.
- Re-start: `start` while `done`=1 → `done` low next cycle, second frame rewrites 0..575, `done` again after 578 cycles.

Source files
------------

// File: rtl/conv1_out_mem_writer.sv
// conv1_out_mem_writer
// Write-side address generator for the conv1 output memory. Consumes a
// valid/ready stream of channel-1/channel-2 result pairs and writes them in
// row-major order into two channel maps, then raises a held done level.
// All outputs except in_ready are registered; in_ready is decoded from state.

module conv1_out_mem_writer #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 24,
    parameter int COLS   = 24,
    parameter int ADDR_W = 10,
    parameter int BASE1  = 0,
    parameter int BASE2  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr1,
    output logic [ADDR_W-1:0] wr_addr2,
    output logic [DATA_W-1:0] wr_data1,
    output logic [DATA_W-1:0] wr_data2,
    output logic              done
);

    // Counter widths; guard against a degenerate 1-wide map dimension.
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] BASE1_A  = ADDR_W'(BASE1);
    localparam logic [ADDR_W-1:0] BASE2_A  = ADDR_W'(BASE2);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [ROW_W-1:0]    row_q,      row_d;
    logic [COL_W-1:0]    col_q,      col_d;
    // Running row*COLS so that no multiplier is needed for the address.
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic                wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0]   wr_addr1_q, wr_addr1_d;
    logic [ADDR_W-1:0]   wr_addr2_q, wr_addr2_d;
    logic [DATA_W-1:0]   wr_data1_q, wr_data1_d;
    logic [DATA_W-1:0]   wr_data2_q, wr_data2_d;
    logic                done_q,     done_d;

    logic                accept_s;
    logic                col_end_s;
    logic                last_s;
    logic [ADDR_W-1:0]   offset_s;

    assign in_ready  = (state_q == ST_WRITE);
    assign accept_s  = in_valid && (state_q == ST_WRITE);
    assign col_end_s = (col_q == COL_LAST);
    assign last_s    = col_end_s && (row_q == ROW_LAST);
    assign offset_s  = row_base_q + ADDR_W'(col_q);

    assign wr_en     = wr_en_q;
    assign wr_addr1  = wr_addr1_q;
    assign wr_addr2  = wr_addr2_q;
    assign wr_data1  = wr_data1_q;
    assign wr_data2  = wr_data2_q;
    assign done      = done_q;

    // Next-state, counter and output-register computation.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        wr_en_d    = 1'b0;
        wr_addr1_d = wr_addr1_q;
        wr_addr2_d = wr_addr2_q;
        wr_data1_d = wr_data1_q;
        wr_data2_d = wr_data2_q;
        done_d     = done_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_WRITE;
                    row_d      = '0;
                    col_d      = '0;
                    row_base_d = '0;
                    done_d     = 1'b0;
                end else begin
                    state_d    = state_q;
                end
            end

            ST_WRITE: begin
                // start is deliberately ignored here: no mid-frame restart.
                if (accept_s) begin
                    wr_en_d    = 1'b1;
                    wr_addr1_d = BASE1_A + offset_s;
                    wr_addr2_d = BASE2_A + offset_s;
                    wr_data1_d = in_data1;
                    wr_data2_d = in_data2;
                    if (last_s) begin
                        // Counters stay on the last cell; the map is complete.
                        state_d = ST_FLUSH;
                    end else if (col_end_s) begin
                        col_d      = '0;
                        row_d      = row_q + ROW_W'(1);
                        row_base_d = row_base_q + COLS_A;
                    end else begin
                        col_d      = col_q + COL_W'(1);
                    end
                end else begin
                    wr_en_d = 1'b0;
                end
            end

            ST_FLUSH: begin
                // The final write is on the port this cycle; done follows it.
                state_d = ST_DONE;
                done_d  = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset drops wr_en immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr1_q <= BASE1_A;
            wr_addr2_q <= BASE2_A;
            wr_data1_q <= '0;
            wr_data2_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            wr_en_q    <= wr_en_d;
            wr_addr1_q <= wr_addr1_d;
            wr_addr2_q <= wr_addr2_d;
            wr_data1_q <= wr_data1_d;
            wr_data2_q <= wr_data2_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_conv1_out_mem_writer.sv
// Directed bench for conv1_out_mem_writer: 24x24 map, BASE1=0, BASE2=576,
// ADDR_W=11 so both maps fit. Data on each beat is the beat index (ch1) and
// the beat index xor 16'hA5A5 (ch2), so the expected write stream is known.

module tb_conv1_out_mem_writer;

    localparam int DATA_W = 16;
    localparam int ROWS   = 24;
    localparam int COLS   = 24;
    localparam int ADDR_W = 11;
    localparam int BASE1  = 0;
    localparam int BASE2  = 576;
    localparam int NPIX   = ROWS * COLS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data1 = '0;
    logic [DATA_W-1:0] in_data2 = '0;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr1;
    logic [ADDR_W-1:0] wr_addr2;
    logic [DATA_W-1:0] wr_data1;
    logic [DATA_W-1:0] wr_data2;
    logic              done;

    int   n_vec = 0;
    int   n_err = 0;
    int   beat  = 0;
    logic acc;
    logic acc_prev = 1'b0;

    conv1_out_mem_writer #(
        .DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS),
        .ADDR_W(ADDR_W), .BASE1(BASE1), .BASE2(BASE2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_data1(in_data1), .in_data2(in_data2),
        .in_ready(in_ready), .wr_en(wr_en),
        .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
        .wr_data1(wr_data1), .wr_data2(wr_data2), .done(done)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, note whether the beat is taken, step past the
    // edge and leave outputs ready for sampling.
    task automatic drive_cycle(input logic v, input logic s);
        in_valid = v;
        start    = s;
        in_data1 = beat[15:0];
        in_data2 = beat[15:0] ^ 16'hA5A5;
        #1;
        acc = v & in_ready;
        @(posedge clk);
        #1;
        if (acc) beat++;
        acc_prev = acc;
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec += 6;
        if (wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en got %b want 0", wr_en); end
        if (wr_addr1 !== 11'd0) begin n_err++; $display("FAIL rst_addr1 got %0d want 0", wr_addr1); end
        if (wr_addr2 !== 11'd576) begin n_err++; $display("FAIL rst_addr2 got %0d want 576", wr_addr2); end
        if (wr_data1 !== 16'd0 || wr_data2 !== 16'd0) begin n_err++; $display("FAIL rst_data got %h/%h want 0/0", wr_data1, wr_data2); end
        if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done); end
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Gap-free frame; from_done also checks that start clears a held done.
    task automatic test_full_frame(input bit from_done);
        int   exp_i;
        logic exp_wr, exp_done;
        exp_i = 0;
        beat  = 0;
        if (from_done) begin
            n_vec++;
            if (done !== 1'b1) begin n_err++; $display("FAIL pre_restart_done got %b want 1", done); end
        end
        drive_cycle(1'b1, 1'b1);
        n_vec += 2;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL start_in_ready got %b want 1", in_ready); end
        if (done !== 1'b0) begin n_err++; $display("FAIL start_done_drop got %b want 0", done); end
        for (int j = 1; j <= 580; j++) begin
            drive_cycle(1'b1, 1'b0);
            exp_wr   = (j <= NPIX);
            exp_done = (j >= NPIX + 1);
            n_vec += 2;
            if (wr_en !== exp_wr) begin n_err++; $display("FAIL frame_wr_en edge %0d got %b want %b", j, wr_en, exp_wr); end
            if (done !== exp_done) begin n_err++; $display("FAIL frame_done edge %0d got %b want %b", j, done, exp_done); end
            if (wr_en === 1'b1) begin
                n_vec += 4;
                if (wr_addr1 !== exp_i[10:0]) begin n_err++; $display("FAIL frame_addr1 got %0d want %0d", wr_addr1, exp_i); end
                if (wr_addr2 !== exp_i[10:0] + 11'd576) begin n_err++; $display("FAIL frame_addr2 got %0d want %0d", wr_addr2, exp_i + 576); end
                if (wr_data1 !== exp_i[15:0]) begin n_err++; $display("FAIL frame_data1 got %0d want %0d", wr_data1, exp_i); end
                if (wr_data2 !== (exp_i[15:0] ^ 16'hA5A5)) begin n_err++; $display("FAIL frame_data2 got %h want %h", wr_data2, exp_i[15:0] ^ 16'hA5A5); end
                if (j == 25) begin
                    n_vec++;
                    if (wr_addr1 !== 11'd24 || wr_addr2 !== 11'd600) begin n_err++; $display("FAIL row_wrap got %0d/%0d want 24/600", wr_addr1, wr_addr2); end
                end
                if (j == 576) begin
                    n_vec++;
                    if (wr_addr1 !== 11'd575 || wr_addr2 !== 11'd1151) begin n_err++; $display("FAIL last_beat got %0d/%0d want 575/1151", wr_addr1, wr_addr2); end
                end
                exp_i++;
            end
        end
        n_vec++;
        if (exp_i != NPIX) begin n_err++; $display("FAIL frame_count got %0d want %0d", exp_i, NPIX); end
    endtask

    task automatic test_backpressure();
        int exp_i;
        int k;
        exp_i = 0;
        beat  = 0;
        k     = 0;
        drive_cycle(1'b0, 1'b1);
        while (done !== 1'b1 && k < 2000) begin
            drive_cycle((k % 4 == 0) || (k % 4 == 3), 1'b0);
            k++;
            n_vec++;
            if (wr_en !== acc_prev) begin n_err++; $display("FAIL bp_wr_en cycle %0d got %b want %b", k, wr_en, acc_prev); end
            if (wr_en === 1'b1) begin
                n_vec += 3;
                if (wr_addr1 !== exp_i[10:0]) begin n_err++; $display("FAIL bp_addr1 got %0d want %0d", wr_addr1, exp_i); end
                if (wr_addr2 !== exp_i[10:0] + 11'd576) begin n_err++; $display("FAIL bp_addr2 got %0d want %0d", wr_addr2, exp_i + 576); end
                if (done !== 1'b0) begin n_err++; $display("FAIL bp_done_with_wr got %b want 0", done); end
                exp_i++;
            end
        end
        n_vec += 2;
        if (done !== 1'b1) begin n_err++; $display("FAIL bp_timeout done got %b want 1", done); end
        if (exp_i != NPIX) begin n_err++; $display("FAIL bp_count got %0d want %0d", exp_i, NPIX); end
    endtask

    task automatic test_ignored_start();
        int   exp_i;
        int   rises;
        int   k;
        logic done_prev;
        exp_i     = 0;
        rises     = 0;
        k         = 0;
        beat      = 0;
        done_prev = 1'b1;
        drive_cycle(1'b1, 1'b1);
        done_prev = done;
        while (k < 700) begin
            drive_cycle(1'b1, (beat == 300));
            k++;
            if (done === 1'b1 && done_prev === 1'b0) rises++;
            done_prev = done;
            if (wr_en === 1'b1) begin
                n_vec++;
                if (wr_addr1 !== exp_i[10:0]) begin n_err++; $display("FAIL ign_addr1 got %0d want %0d", wr_addr1, exp_i); end
                exp_i++;
            end
            if (k > 590) break;
        end
        n_vec += 3;
        if (exp_i != NPIX) begin n_err++; $display("FAIL ign_count got %0d want %0d", exp_i, NPIX); end
        if (rises != 1) begin n_err++; $display("FAIL ign_done_rises got %0d want 1", rises); end
        if (done !== 1'b1) begin n_err++; $display("FAIL ign_done_held got %b want 1", done); end
    endtask

    task automatic test_reset_midframe();
        beat = 0;
        drive_cycle(1'b1, 1'b1);
        repeat (100) drive_cycle(1'b1, 1'b0);
        n_vec++;
        if (wr_en !== 1'b1 || wr_addr1 !== 11'd99) begin n_err++; $display("FAIL mid_pre got %b/%0d want 1/99", wr_en, wr_addr1); end
        #2 rst_n = 1'b0;
        #1;
        n_vec += 4;
        if (wr_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_wr_en got %b want 0", wr_en); end
        if (done !== 1'b0) begin n_err++; $display("FAIL mid_rst_done got %b want 0", done); end
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_in_ready got %b want 0", in_ready); end
        if (wr_addr1 !== 11'd0 || wr_addr2 !== 11'd576) begin n_err++; $display("FAIL mid_rst_addr got %0d/%0d want 0/576", wr_addr1, wr_addr2); end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat = 0;
        drive_cycle(1'b1, 1'b1);
        drive_cycle(1'b1, 1'b0);
        n_vec += 2;
        if (wr_en !== 1'b1 || wr_addr1 !== 11'd0) begin n_err++; $display("FAIL mid_restart got %b/%0d want 1/0", wr_en, wr_addr1); end
        if (wr_data1 !== 16'd0) begin n_err++; $display("FAIL mid_restart_data got %0d want 0", wr_data1); end
    endtask

    initial begin
        test_reset();
        test_full_frame(1'b0);
        test_full_frame(1'b1);
        test_backpressure();
        test_ignored_start();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
